sobel_window_convolver: RTL and testbench

//  Downstream consumer of matrixgenerator. Snapshots the scaled 3x3 X/Y kernels and

---
 rtl/sobel_pkg.sv | 42 ++++
 rtl/sobel_window_convolver_if.sv | 31 +++
 rtl/sobel_mac_lane.sv | 56 +++++
 rtl/sobel_window_convolver.sv | 144 ++++++++++++++
 tb/tb_sobel_window_convolver.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared widths, kernel/state types and small arithmetic helpers for the Sobel window convolver.
package sobel_pkg;

    localparam int unsigned PIX_W    = 8;
    localparam int unsigned COEF_W   = 5;
    localparam int unsigned ACC_W    = 18;
    localparam int unsigned OUT_W    = 8;
    localparam int unsigned PROD_W   = PIX_W + COEF_W + 1;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned LAST_IDX = 8;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef coef_t [0:2][0:2]         kernel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } state_t;

    // Row-major coefficient select: idx 0..8 maps to [idx/3][idx%3].
    function automatic coef_t kernel_pick(input kernel_t k, input logic [IDX_W-1:0] idx);
        coef_t c_sel;
        c_sel = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (idx == IDX_W'(r * 3 + c)) begin
                    c_sel = k[r][c];
                end
            end
        end
        return c_sel;
    endfunction

    // Absolute value one bit wider than the input so the most negative value stays exact.
    function automatic logic [ACC_W:0] abs_ext(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W:0] e;
        e = {v[ACC_W-1], v};
        return e[ACC_W] ? $unsigned((ACC_W+1)'(-e)) : $unsigned(e);
    endfunction

endpackage

// File: rtl/sobel_window_convolver_if.sv
// Kernel inputs, pixel stream and result handshake for the Sobel window convolver.
interface sobel_window_convolver_if;
    import sobel_pkg::*;

    kernel_t                  kx;
    kernel_t                  ky;
    logic                     start;
    logic                     pixel_valid;
    logic [PIX_W-1:0]         pixel_data;
    logic                     pixel_ready;
    logic                     result_valid;
    logic                     result_ready;
    logic signed [ACC_W-1:0]  gx;
    logic signed [ACC_W-1:0]  gy;
    logic [OUT_W-1:0]         grad;
    logic                     sat;
    logic                     busy;

    // Producer/consumer side (kernel source, pixel feeder, result sink).
    modport master (
        output kx, ky, start, pixel_valid, pixel_data, result_ready,
        input  pixel_ready, result_valid, gx, gy, grad, sat, busy
    );

    // Convolver side.
    modport slave (
        input  kx, ky, start, pixel_valid, pixel_data, result_ready,
        output pixel_ready, result_valid, gx, gy, grad, sat, busy
    );

endinterface

// File: rtl/sobel_mac_lane.sv
// One multiply-accumulate lane: kernel snapshot, coefficient select, signed MAC.
module sobel_mac_lane
    import sobel_pkg::*;
(
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     load,
    input  kernel_t                  kernel_in,
    input  logic                     en,
    input  logic [IDX_W-1:0]         idx,
    input  logic [PIX_W-1:0]         pix,
    output logic signed [ACC_W-1:0]  acc_sum_c
);

    kernel_t                  kern_q, kern_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    coef_t                    coef_c;
    logic signed [PROD_W-1:0] pix_ext_c;
    logic signed [PROD_W-1:0] coef_ext_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [ACC_W-1:0]  prod_ext_c;

    // Operands widened to the product width; true product always fits in PROD_W bits.
    always_comb begin
        coef_c     = kernel_pick(kern_q, idx);
        pix_ext_c  = $signed({{(PROD_W-PIX_W){1'b0}}, pix});
        coef_ext_c = $signed({{(PROD_W-COEF_W){coef_c[COEF_W-1]}}, coef_c});
        prod_c     = pix_ext_c * coef_ext_c;
        prod_ext_c = $signed({{(ACC_W-PROD_W){prod_c[PROD_W-1]}}, prod_c});
        acc_sum_c  = acc_q + prod_ext_c;
    end

    // Snapshot the kernel and clear on load; accumulate on each accepted beat.
    always_comb begin
        kern_d = kern_q;
        acc_d  = acc_q;
        if (load) begin
            kern_d = kernel_in;
            acc_d  = '0;
        end else if (en) begin
            acc_d  = acc_sum_c;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            kern_q <= '0;
            acc_q  <= '0;
        end else begin
            kern_q <= kern_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/sobel_window_convolver.sv
// 3x3 Sobel window convolver: serial X/Y MACs over a 9-beat pixel stream, saturated |Gx|+|Gy|.
module sobel_window_convolver
    import sobel_pkg::*;
(
    input  logic                     clk,
    input  logic                     n_rst,
    sobel_window_convolver_if.slave  bus
);

    localparam int unsigned SUM_W = ACC_W + 2;
    localparam logic [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** OUT_W) - 1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    pixel_ready_q, pixel_ready_d;
    logic                    result_valid_q, result_valid_d;
    logic                    busy_q, busy_d;
    logic signed [ACC_W-1:0] gx_q, gx_d;
    logic signed [ACC_W-1:0] gy_q, gy_d;
    logic [OUT_W-1:0]        grad_q, grad_d;
    logic                    sat_q, sat_d;

    logic                    load_c;
    logic                    accept_c;
    logic signed [ACC_W-1:0] acc_x_sum_c;
    logic signed [ACC_W-1:0] acc_y_sum_c;
    logic [ACC_W:0]          abs_x_c;
    logic [ACC_W:0]          abs_y_c;
    logic [SUM_W-1:0]        mag_sum_c;
    logic                    sat_c;
    logic [OUT_W-1:0]        grad_c;

    // Start is honoured only in IDLE; a pixel is taken only while ready is presented.
    assign load_c   = (state_q == IDLE) && bus.start;
    assign accept_c = (state_q == ACCUM) && pixel_ready_q && bus.pixel_valid;

    sobel_mac_lane u_lane_x (
        .clk       (clk),
        .n_rst     (n_rst),
        .load      (load_c),
        .kernel_in (bus.kx),
        .en        (accept_c),
        .idx       (idx_q),
        .pix       (bus.pixel_data),
        .acc_sum_c (acc_x_sum_c)
    );

    sobel_mac_lane u_lane_y (
        .clk       (clk),
        .n_rst     (n_rst),
        .load      (load_c),
        .kernel_in (bus.ky),
        .en        (accept_c),
        .idx       (idx_q),
        .pix       (bus.pixel_data),
        .acc_sum_c (acc_y_sum_c)
    );

    // Magnitude from the post-beat sums so the result is ready the cycle after beat 9.
    always_comb begin
        abs_x_c   = abs_ext(acc_x_sum_c);
        abs_y_c   = abs_ext(acc_y_sum_c);
        mag_sum_c = {1'b0, abs_x_c} + {1'b0, abs_y_c};
        sat_c     = (mag_sum_c > SAT_MAX);
        grad_c    = sat_c ? '1 : mag_sum_c[OUT_W-1:0];
    end

    // Next-state, beat counter and result capture.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gx_d    = gx_q;
        gy_d    = gy_q;
        grad_d  = grad_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACCUM;
                    idx_d   = '0;
                end
            end
            ACCUM: begin
                if (accept_c) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(LAST_IDX)) begin
                        state_d = RESULT;
                        idx_d   = '0;
                        gx_d    = acc_x_sum_c;
                        gy_d    = acc_y_sum_c;
                        grad_d  = grad_c;
                        sat_d   = sat_c;
                    end
                end
            end
            RESULT: begin
                if (bus.result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
        pixel_ready_d  = (state_d == ACCUM);
        result_valid_d = (state_d == RESULT);
        busy_d         = (state_d != IDLE);
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            pixel_ready_q  <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            gx_q           <= '0;
            gy_q           <= '0;
            grad_q         <= '0;
            sat_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            pixel_ready_q  <= pixel_ready_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            gx_q           <= gx_d;
            gy_q           <= gy_d;
            grad_q         <= grad_d;
            sat_q          <= sat_d;
        end
    end

    assign bus.pixel_ready  = pixel_ready_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = busy_q;
    assign bus.gx           = gx_q;
    assign bus.gy           = gy_q;
    assign bus.grad         = grad_q;
    assign bus.sat          = sat_q;

endmodule

// File: tb/tb_sobel_window_convolver.sv
// Directed bench for the Sobel window convolver with hand-computed gradients.
module tb_sobel_window_convolver;
    import sobel_pkg::*;

    logic clk;
    logic n_rst;
    int   tests;
    int   failures;

    kernel_t KX;
    kernel_t KY;

    int unsigned px_flat100 [9];
    int unsigned px_vedge   [9];
    int unsigned px_hedge   [9];
    int unsigned px_flat7   [9];

    sobel_window_convolver_if bus ();

    sobel_window_convolver dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start a window, optionally overlapping start with pixel_valid, scrambling the
    // kernel inputs after the snapshot, and inserting an idle gap before one beat.
    task automatic send_window(input int unsigned px [9], input bit scramble,
                               input int gap_beat, input int gap_len, input bit overlap);
        bus.start = 1'b1;
        if (overlap) begin
            bus.pixel_valid = 1'b1;
            bus.pixel_data  = 8'hFF;
        end
        @(negedge clk);
        bus.start       = 1'b0;
        bus.pixel_valid = 1'b0;
        check("accum_ready", bus.pixel_ready, 1);
        check("accum_busy", bus.busy, 1);
        if (scramble) begin
            bus.kx = '0;
            bus.ky = '0;
        end
        for (int i = 0; i < 9; i++) begin
            if (i == gap_beat) begin
                bus.pixel_valid = 1'b0;
                repeat (gap_len) @(negedge clk);
                check("gap_hold_ready", bus.pixel_ready, 1);
            end
            if (i == 8) check("pre_last_no_valid", bus.result_valid, 0);
            bus.pixel_valid = 1'b1;
            bus.pixel_data  = 8'(px[i]);
            @(negedge clk);
        end
        bus.pixel_valid = 1'b0;
        bus.kx = KX;
        bus.ky = KY;
        check("latency_valid", bus.result_valid, 1);
    endtask

    // Check a presented result, then complete the handshake and confirm return to IDLE.
    task automatic check_result(input string tag, input int egx, input int egy,
                                input int egrad, input int esat);
        check({tag, "_valid"}, bus.result_valid, 1);
        check({tag, "_gx"}, bus.gx, egx);
        check({tag, "_gy"}, bus.gy, egy);
        check({tag, "_grad"}, bus.grad, egrad);
        check({tag, "_sat"}, bus.sat, esat);
        check({tag, "_noready"}, bus.pixel_ready, 0);
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        check({tag, "_done_valid"}, bus.result_valid, 0);
        check({tag, "_done_busy"}, bus.busy, 0);
    endtask

    initial begin
        int kxv [3][3];
        int kyv [3][3];
        tests    = 0;
        failures = 0;
        kxv = '{'{1, 0, -1}, '{2, 0, -2}, '{1, 0, -1}};
        kyv = '{'{1, 2, 1}, '{0, 0, 0}, '{-1, -2, -1}};
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                KX[r][c] = COEF_W'(kxv[r][c]);
                KY[r][c] = COEF_W'(kyv[r][c]);
                px_flat100[r*3+c] = 100;
                px_vedge[r*3+c]   = (c == 0) ? 10 : ((c == 1) ? 30 : 50);
                px_hedge[r*3+c]   = (r == 0) ? 200 : 0;
                px_flat7[r*3+c]   = 7;
            end
        end

        n_rst            = 1'b0;
        bus.kx           = KX;
        bus.ky           = KY;
        bus.start        = 1'b0;
        bus.pixel_valid  = 1'b0;
        bus.pixel_data   = '0;
        bus.result_ready = 1'b0;

        // Power-on reset values
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_pixel_ready", bus.pixel_ready, 0);
        check("rst_result_valid", bus.result_valid, 0);
        check("rst_gx", bus.gx, 0);
        check("rst_gy", bus.gy, 0);
        check("rst_grad", bus.grad, 0);
        check("rst_sat", bus.sat, 0);
        n_rst = 1'b1;
        @(negedge clk);
        check("idle_no_ready", bus.pixel_ready, 0);

        // Flat field of 100: no gradient
        send_window(px_flat100, 1'b0, -1, 0, 1'b0);
        check_result("flat100", 0, 0, 0, 0);

        // Vertical edge, start overlapping a pixel, kernel inputs zeroed after snapshot
        send_window(px_vedge, 1'b1, -1, 0, 1'b1);
        check_result("vedge", -160, 0, 160, 0);

        // Horizontal edge saturates; hold off the result and poke start meanwhile
        send_window(px_hedge, 1'b0, -1, 0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            bus.start = (k == 2);
            @(negedge clk);
            check("bp_valid", bus.result_valid, 1);
            check("bp_gy", bus.gy, 800);
            check("bp_grad", bus.grad, 255);
            check("bp_no_pixel_ready", bus.pixel_ready, 0);
        end
        bus.start = 1'b0;
        check_result("hedge", 0, 800, 255, 1);
        @(negedge clk);
        check("bp_start_ignored", bus.busy, 0);

        // result_ready with nothing pending leaves the block idle
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        check("idle_rr_valid", bus.result_valid, 0);
        check("idle_rr_busy", bus.busy, 0);

        // Reset mid-clock after four beats drops the partial window
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.pixel_valid = 1'b1;
            bus.pixel_data  = 8'd200;
            @(negedge clk);
        end
        bus.pixel_valid = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_pixel_ready", bus.pixel_ready, 0);
        check("midrst_result_valid", bus.result_valid, 0);
        check("midrst_gx", bus.gx, 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        send_window(px_flat7, 1'b0, -1, 0, 1'b0);
        check_result("flat7", 0, 0, 0, 0);

        // Three-cycle pixel_valid gap mid-window gives the same vertical-edge result
        send_window(px_vedge, 1'b0, 4, 3, 1'b0);
        check_result("vedge_gap", -160, 0, 160, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
